// File: rtl/ex_seq_ctrl_pkg.sv
// Shared types and constants for the multi-cycle execute sequencer and the ALU decoder.
package ex_seq_ctrl_pkg;

  localparam int          ALU_CTL_W = 4;
  localparam logic [3:0]  ALU_AND   = 4'b0000;
  localparam logic [3:0]  ALU_OR    = 4'b0001;
  localparam logic [3:0]  ALU_ADD   = 4'b0010;
  localparam logic [3:0]  ALU_SUB   = 4'b0110;
  localparam logic [3:0]  ALU_SLT   = 4'b0111;

  localparam logic [31:0] LINK_INC  = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    TGT  = 2'd2,
    DONE = 2'd3
  } ex_seq_state_t;

  // Decoded instruction as latched at the accept handshake.
  typedef struct packed {
    logic [31:0]          rs1;
    logic [31:0]          rs2;
    logic [31:0]          imm;
    logic [31:0]          pc;
    logic                 alu_src;
    logic [ALU_CTL_W-1:0] alu_control;
    logic                 branch;
    logic                 jump;
  } ex_op_t;

endpackage

// File: rtl/ex_seq_ctrl_if.sv
// Instruction-in, shared-ALU and result-out bundle of the execute sequencer.
// master = upstream/ALU/consumer side, slave = sequencer.
interface ex_seq_ctrl_if;
  import ex_seq_ctrl_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          rs1_data;
  logic [31:0]          rs2_data;
  logic [31:0]          imm;
  logic [31:0]          pc;
  logic                 alu_src;
  logic [ALU_CTL_W-1:0] alu_control;
  logic                 branch;
  logic                 jump;

  logic [31:0]          alu_a;
  logic [31:0]          alu_b;
  logic [ALU_CTL_W-1:0] alu_ctl;
  logic [31:0]          alu_y;
  logic                 alu_zero;

  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          result;
  logic [31:0]          target;
  logic                 take;

  modport master (
    output in_valid, rs1_data, rs2_data, imm, pc, alu_src, alu_control, branch, jump,
    input  in_ready,
    input  alu_a, alu_b, alu_ctl,
    output alu_y, alu_zero,
    input  out_valid, result, target, take,
    output out_ready
  );

  modport slave (
    input  in_valid, rs1_data, rs2_data, imm, pc, alu_src, alu_control, branch, jump,
    output in_ready,
    output alu_a, alu_b, alu_ctl,
    input  alu_y, alu_zero,
    output out_valid, result, target, take,
    input  out_ready
  );

endinterface

// File: rtl/ex_seq_ctrl.sv
// Execute sequencer time-sharing one external ALU between the op and the branch/jump target.
// Latency: accept edge -> out_valid two cycles later; one op per 3 cycles peak.
// Backpressure: holds DONE with stable outputs until out_ready; accepts the next op in that same cycle.
module ex_seq_ctrl
  import ex_seq_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  ex_seq_ctrl_if.slave bus
);

  ex_seq_state_t state, state_nxt;
  ex_op_t        op_q;
  logic [31:0]   result_q;
  logic [31:0]   target_q;
  logic          take_q;
  logic          accept;

  assign bus.in_ready  = !flush && ((state == IDLE) || ((state == DONE) && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.target    = target_q;
  assign bus.take      = take_q;

  always_comb begin
    state_nxt   = state;
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_ctl = '0;
    case (state)
      IDLE: if (accept) state_nxt = OP;
      OP: begin
        // A jump's "result" is the link value, so the op slot computes pc+LINK_INC.
        if (op_q.jump) begin
          bus.alu_a   = op_q.pc;
          bus.alu_b   = LINK_INC;
          bus.alu_ctl = ALU_ADD;
        end else begin
          bus.alu_a   = op_q.rs1;
          bus.alu_b   = op_q.alu_src ? op_q.imm : op_q.rs2;
          bus.alu_ctl = op_q.alu_control;
        end
        state_nxt = TGT;
      end
      TGT: begin
        bus.alu_a   = op_q.pc;
        bus.alu_b   = (op_q.branch || op_q.jump) ? op_q.imm : LINK_INC;
        bus.alu_ctl = ALU_ADD;
        state_nxt   = DONE;
      end
      DONE: if (bus.out_ready) state_nxt = accept ? OP : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      result_q <= '0;
      target_q <= '0;
      take_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q.rs1         <= bus.rs1_data;
        op_q.rs2         <= bus.rs2_data;
        op_q.imm         <= bus.imm;
        op_q.pc          <= bus.pc;
        op_q.alu_src     <= bus.alu_src;
        op_q.alu_control <= bus.alu_control;
        op_q.branch      <= bus.branch;
        op_q.jump        <= bus.jump;
      end
      if (!flush && (state == OP)) begin
        result_q <= bus.alu_y;
        take_q   <= (op_q.branch && bus.alu_zero) || op_q.jump;
      end
      if (!flush && (state == TGT)) target_q <= bus.alu_y;
    end
  end

endmodule
